// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// The FSM state encoding lives here so top and bench agree on it.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock LSB first through one subtractor cell.
// Results are published to separate output registers so they stay put between operations.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sub_state_t       r_state;
    sub_state_t       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br;
    logic             r_amsb;
    logic             r_bmsb;
    logic             r_bout;
    logic             r_ovf;
    logic             w_d;
    logic             w_bo;
    logic             w_last;

    full_subtractor u_cell (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .bi (r_br),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_next = RUN;
            RUN:     if (w_last)      w_next = DONE;
            DONE:    if (res_ready)   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Published flags use the captured operand MSBs, since the operand registers have shifted out by then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_shift  <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_amsb   <= 1'b0;
            r_bmsb   <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_a    <= a_in;
                        r_b    <= b_in;
                        r_br   <= bin;
                        r_cnt  <= '0;
                        r_amsb <= a_in[WIDTH-1];
                        r_bmsb <= b_in[WIDTH-1];
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_shift <= {w_d, r_shift[WIDTH-1:1]};
                    r_br    <= w_bo;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= {w_d, r_shift[WIDTH-1:1]};
                        r_bout   <= w_bo;
                        r_ovf    <= (r_amsb != r_bmsb) && (w_d != r_amsb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (r_state == IDLE);
    assign res_valid   = (r_state == DONE);
    assign result      = r_result;
    assign borrow_out  = r_bout;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at request time
// and compared when the response handshake presents them.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] res;
        logic       bo;
        logic       ovf;
    } expT;

    logic       clk;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       bin;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic       borrow_out;
    logic       overflow;

    expT expQ[$];
    int  testsRun   = 0;
    int  testsFail  = 0;
    int  cyc        = 0;
    int  acceptCycle = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .bin         (bin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .borrow_out  (borrow_out),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference: integer arithmetic, range checks for borrow and signed overflow.
    function automatic expT model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        expT e;
        int  d;
        int  sd;
        d     = int'(a) - int'(b) - int'(bi);
        sd    = int'($signed(a)) - int'($signed(b)) - int'(bi);
        e.res = d[7:0];
        e.bo  = (d < 0);
        e.ovf = (sd > 127) || (sd < -128);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int guard;
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!start_ready) checkOutput("startReadyTimeout", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        bin         = bi;
        expQ.push_back(model(a, b, bi));
        @(posedge clk); #1;
        acceptCycle = cyc;
        start_valid = 1'b0;
        a_in        = 8'($urandom);
        b_in        = 8'($urandom);
        bin         = 1'($urandom);
    endtask

    task automatic waitResult(input string tag);
        int lat;
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'd8);
    endtask

    task automatic popAndCompare(input string tag, output expT e);
        if (expQ.size() == 0) begin
            checkOutput({tag, ".queueEmpty"}, 32'd0, 32'd1);
            e.res = '0; e.bo = 1'b0; e.ovf = 1'b0;
        end else begin
            e = expQ.pop_front();
        end
        checkOutput({tag, ".result"},   32'(result),     32'(e.res));
        checkOutput({tag, ".borrow"},   32'(borrow_out), 32'(e.bo));
        checkOutput({tag, ".overflow"}, 32'(overflow),   32'(e.ovf));
    endtask

    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi);
        expT e;
        applyStimulus(a, b, bi);
        waitResult(tag);
        popAndCompare(tag, e);
        @(posedge clk); #1;
    endtask

    initial begin
        expT e;
        int  prevAccept;

        rst_n       = 1'b0;
        start_valid = 1'b0;
        a_in        = '0;
        b_in        = '0;
        bin         = 1'b0;
        res_ready   = 1'b1;
        #12;
        checkOutput("reset.startReady", 32'(start_ready), 32'd1);
        checkOutput("reset.resValid",   32'(res_valid),   32'd0);
        checkOutput("reset.result",     32'(result),      32'd0);
        checkOutput("reset.borrow",     32'(borrow_out),  32'd0);
        checkOutput("reset.overflow",   32'(overflow),    32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        runOp("basic200m55", 8'd200, 8'd55, 1'b0);
        runOp("under5m10",   8'd5,   8'd10, 1'b0);
        runOp("ovf80m01",    8'h80,  8'h01, 1'b0);
        runOp("zeroBin",     8'h00,  8'h00, 1'b1);
        runOp("ffmff",       8'hFF,  8'hFF, 1'b0);
        runOp("ovf80m7fBin", 8'h80,  8'h7F, 1'b1);

        // Consumer stalls for 5 cycles while a new request is pending.
        res_ready = 1'b0;
        applyStimulus(8'h30, 8'h10, 1'b0);
        waitResult("bp");
        popAndCompare("bp.first", e);
        start_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            checkOutput("bp.holdResult", 32'(result),      32'(e.res));
            checkOutput("bp.holdBorrow", 32'(borrow_out),  32'(e.bo));
            checkOutput("bp.holdOvf",    32'(overflow),    32'(e.ovf));
            checkOutput("bp.startReady", 32'(start_ready), 32'd0);
            checkOutput("bp.resValid",   32'(res_valid),   32'd1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        checkOutput("bp.releaseValid", 32'(res_valid),   32'd0);
        checkOutput("bp.releaseReady", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("bp.notTaken",     32'(start_ready), 32'd1);
        checkOutput("bp.resultKept",   32'(result),      32'(e.res));

        // Reset three cycles into an operation discards it.
        applyStimulus(8'h55, 8'h22, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("rst.resValid",   32'(res_valid),   32'd0);
        checkOutput("rst.result",     32'(result),      32'd0);
        checkOutput("rst.borrow",     32'(borrow_out),  32'd0);
        checkOutput("rst.overflow",   32'(overflow),    32'd0);
        checkOutput("rst.startReady", 32'(start_ready), 32'd1);
        void'(expQ.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        runOp("rst.after9m4", 8'd9, 8'd4, 1'b0);

        // Back-to-back random traffic with the consumer always ready.
        prevAccept = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
            if (i > 0) checkOutput("b2b.spacing", 32'(acceptCycle - prevAccept), 32'd10);
            prevAccept = acceptCycle;
            waitResult("b2b");
            popAndCompare("b2b", e);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b - bin` over `WIDTH` bits, one bit per clock, LSB first, through a single full-subtractor cell. It sits alongside the combinational adder datapath as the area-minimal inverse operation for slow control paths. Operands are taken on a valid/ready request handshake, and the difference is returned on a valid/ready response handshake with borrow and signed-overflow flags.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal when ≥ 2.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start_valid`  in  1  request: operands present.
- `start_ready`  out  1  block idle and able to accept.
- `a_in`  in  `WIDTH`  minuend.
- `b_in`  in  `WIDTH`  subtrahend.
- `bin`  in  1  borrow-in, sampled with the operands.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `result`  out  `WIDTH`  difference, modulo 2^`WIDTH`.
- `borrow_out`  out  1  final borrow: unsigned `a` < `b` + `bin`.
- `overflow`  out  1  signed overflow of the two's-complement difference.

## Operation
- States: `IDLE`, `RUN`, `DONE`.
- **IDLE**
  - `start_ready` = 1.
  - On `start_valid` && `start_ready`: latch `a_in` and `b_in` into shift registers, load the borrow flop with `bin`, clear the bit counter, latch the operand MSBs `a_msb` and `b_msb`, and go to `RUN`.
- **RUN**, each cycle:
  - `d = a0 ^ b0 ^ br`.
  - `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - Shift both operand registers right by 1.
  - Shift `result` right, inserting `d` at the MSB.
  - Increment the counter.
- **RUN → DONE** at the edge that processes bit `WIDTH-1`. At that edge:
  - `borrow_out` ← `br'`.
  - `overflow` ← (`a_msb` != `b_msb`) && (`d` != `a_msb`), where `d` is the bit-`WIDTH-1` difference.
- **DONE**
  - `res_valid` = 1.
  - `result`, `borrow_out` and `overflow` are held stable while `res_valid` && !`res_ready`.
  - On `res_ready`: go to `IDLE`.
- `start_ready` = (state == `IDLE`); `res_valid` = (state == `DONE`). Both are decoded from state, not registered separately.
- `start_valid` outside `IDLE` is ignored. Operand inputs are don't-care except on the accepting edge.
- After consumption, `result`, `borrow_out` and `overflow` keep their last values until the next `DONE` update.
- Arithmetic is purely modular. `borrow_out` reports unsigned underflow and `overflow` reports signed overflow; the two are independent.
- Reset (asserted at any time, including mid-`RUN`): state ← `IDLE`, counter ← 0, borrow flop ← 0, operand registers ← 0.
  - Output values during and after reset: `result` = 0, `borrow_out` = 0, `overflow` = 0, `res_valid` = 0, `start_ready` = 1.
  - An in-flight operation is discarded; no partial result is ever flagged valid.

## Timing
- Acceptance edge E0. `RUN` spans edges E1..E`WIDTH`, where E`k` processes bit `k-1`.
- `res_valid` rises after edge E`WIDTH`, i.e. exactly `WIDTH` cycles after acceptance.
- Handshake completes on the first edge with `res_valid` && `res_ready`. `start_ready` rises after that edge.
- Minimum request-to-request spacing is `WIDTH` + 2 cycles when `res_ready` is held at 1.
- No combinational path from any input to any output. `start_ready` and `res_valid` depend on state only.
- Counter width is `$clog2(WIDTH)`. Terminal count is `WIDTH-1`, compared before increment.

## Structure
- Package `serial_sub_pkg`:
  - state enum `sub_state_t` {`IDLE`, `RUN`, `DONE`}, 2-bit encoding.
  - `SUB_WIDTH_DEFAULT` = 8.
- Sub-module `full_subtractor`:
  - inputs `a`, `b`, `bi`; outputs `d`, `bo`.
  - purely combinational, one instance, implementing the `d` and `br'` equations above.
- Top level holds the FSM, counter, operand and result shift registers, borrow flop, and `a_msb`/`b_msb` capture.

## Test plan
- `a`=200, `b`=55, `bin`=0 → `result`=145 (0x91), `borrow_out`=0, `overflow`=0. `res_valid` asserted exactly 8 cycles after acceptance.
- `a`=5, `b`=10, `bin`=0 → `result`=0xFB, `borrow_out`=1, `overflow`=0. Then `a`=0x80, `b`=0x01 → `result`=0x7F, `borrow_out`=0, `overflow`=1.
- `a`=0x00, `b`=0x00, `bin`=1 → `result`=0xFF, `borrow_out`=1, `overflow`=0. `a`=0xFF, `b`=0xFF, `bin`=0 → `result`=0x00, `borrow_out`=0.
- Backpressure:
  - Stimulus: `res_ready` held 0 for 5 cycles in `DONE`, with `start_valid`=1 and new operands driven throughout.
  - Response: `result`, `borrow_out` and `overflow` stable; `start_ready`=0; new operands not taken.
  - On release: one transfer, then `start_ready`=1 the next cycle.
- Reset mid-`RUN`:
  - Stimulus: `rst_n` pulsed low 3 cycles after acceptance.
  - Response: immediately `res_valid`=0, `result`=0, `borrow_out`=0, `overflow`=0, `start_ready`=1.
  - A following request with `a`=9, `b`=4 yields 5 after 8 cycles.
- Back-to-back: 20 random operand pairs with `res_ready`=1. Each result matches `(a - b - bin) mod 256`, borrow and signed-overflow reference values, with spacing of exactly 10 cycles.
